// File: rtl/xor_checksum_checker.sv
// XOR checksum checker: folds 64-bit payload words and compares the result against a trailing checksum word.
// Verdict pulses on done one cycle after the checksum word; in_ready drops only for that verdict cycle.
module xor_checksum_checker #(
   parameter int MAX_WORDS = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        overflow,
   output logic [7:0]  word_count
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   state_t      state;
   logic [63:0] acc;
   logic        discard;
   logic        accept;

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         word_count <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         overflow   <= 1'b0;
         discard    <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  // After an overflow, the rest of the oversized packet is swallowed here.
                  if (discard) begin
                     if (in_last) begin
                        discard <= 1'b0;
                     end
                  end else if (in_last) begin
                     pass       <= (in_data == 64'h0);
                     fail       <= (in_data != 64'h0);
                     overflow   <= 1'b0;
                     word_count <= 8'd0;
                     done       <= 1'b1;
                     in_ready   <= 1'b0;
                     state      <= REPORT;
                  end else begin
                     acc        <= in_data;
                     word_count <= 8'd1;
                     state      <= ACCUM;
                  end
               end
            end

            ACCUM: begin
               if (accept) begin
                  if (in_last) begin
                     pass     <= (acc == in_data);
                     fail     <= (acc != in_data);
                     overflow <= 1'b0;
                     done     <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= REPORT;
                  end else if (word_count == MAX_CNT) begin
                     pass     <= 1'b0;
                     fail     <= 1'b1;
                     overflow <= 1'b1;
                     discard  <= 1'b1;
                     done     <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= REPORT;
                  end else begin
                     acc        <= acc ^ in_data;
                     word_count <= word_count + 8'd1;
                  end
               end
            end

            REPORT: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end

            default: begin
               in_ready <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

   verdict_exclusive: assert property (@(posedge clk) disable iff (reset) !(pass && fail));
   no_accept_in_report: assert property (@(posedge clk) disable iff (reset) done |-> !in_ready);

endmodule

// File: tb/tb_xor_checksum_checker.sv
// Directed bench: packet-level queue model checked every cycle, plus hand-computed literal expectations.
module tb_xor_checksum_checker;

   localparam int MAXW = 4;

   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic [63:0] in_data  = '0;
   logic        in_valid = 1'b0;
   logic        in_last  = 1'b0;
   logic        in_ready, done, pass, fail, overflow;
   logic [7:0]  word_count;

   int errors = 0;
   int checks = 0;
   int ndone  = 0;
   int n0     = 0;
   bit finished = 1'b0;

   always #5 clk = ~clk;

   xor_checksum_checker #(.MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .done       (done),
      .pass       (pass),
      .fail       (fail),
      .overflow   (overflow),
      .word_count (word_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Packet model: payload words collected in a queue, verdict is the XOR-reduction vs the checksum.
   logic [63:0] m_q[$];
   logic [63:0] m_x;
   logic        m_rdy  = 1'b1;
   logic        m_done = 1'b0;
   logic        m_pass = 1'b0;
   logic        m_fail = 1'b0;
   logic        m_ovf  = 1'b0;
   logic        m_drop = 1'b0;
   int          m_cnt  = 0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_q.delete();
         m_rdy = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
         m_ovf = 1'b0; m_drop = 1'b0; m_cnt = 0;
      end else begin
         m_done = 1'b0;
         if (!m_rdy) begin
            m_rdy = 1'b1;
         end else if (in_valid) begin
            if (m_drop) begin
               if (in_last) m_drop = 1'b0;
            end else if (in_last) begin
               m_x = '0;
               foreach (m_q[i]) m_x = m_x ^ m_q[i];
               m_pass = (m_x == in_data);
               m_fail = !m_pass;
               m_ovf  = 1'b0;
               m_cnt  = m_q.size();
               m_q.delete();
               m_done = 1'b1;
               m_rdy  = 1'b0;
            end else if (m_q.size() == MAXW) begin
               m_pass = 1'b0;
               m_fail = 1'b1;
               m_ovf  = 1'b1;
               m_cnt  = MAXW;
               m_q.delete();
               m_drop = 1'b1;
               m_done = 1'b1;
               m_rdy  = 1'b0;
            end else begin
               m_q.push_back(in_data);
               m_cnt = m_q.size();
            end
         end
      end
   end

   initial begin
      while (!finished) begin
         @(negedge clk);
         chk("in_ready",   64'(in_ready),   64'(m_rdy));
         chk("done",       64'(done),       64'(m_done));
         chk("pass",       64'(pass),       64'(m_pass));
         chk("fail",       64'(fail),       64'(m_fail));
         chk("overflow",   64'(overflow),   64'(m_ovf));
         chk("word_count", 64'(word_count), 64'(m_cnt));
         if (done === 1'b1) ndone++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic word(input logic [63:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_count", 64'(word_count), 64'd0);
      chk("rst_done",  64'(done),       64'd0);
      chk("rst_pass",  64'(pass),       64'd0);
      chk("rst_fail",  64'(fail),       64'd0);
      reset = 1'b0;
      tick();
      chk("rst_ready", 64'(in_ready), 64'd1);

      // 8324 ^ 7813266 = 0x771816
      word(64'd8324, 1'b0);
      word(64'd7813266, 1'b0);
      word(64'h771816, 1'b1);
      chk("p1_done",  64'(done),       64'd1);
      chk("p1_pass",  64'(pass),       64'd1);
      chk("p1_fail",  64'(fail),       64'd0);
      chk("p1_count", 64'(word_count), 64'd2);
      tick();
      chk("p1_done_off", 64'(done),       64'd0);
      chk("p1_hold",     64'(word_count), 64'd2);

      word(64'd8324, 1'b0);
      word(64'd7813266, 1'b0);
      word(64'h771817, 1'b1);
      chk("p2_fail", 64'(fail),     64'd1);
      chk("p2_pass", 64'(pass),     64'd0);
      chk("p2_ovf",  64'(overflow), 64'd0);
      tick();

      // Mismatch only in bit 63
      word(64'h8000_0000_0000_0001, 1'b0);
      word(64'h1, 1'b1);
      chk("msb_fail", 64'(fail), 64'd1);
      tick();

      word(64'h0, 1'b1);
      chk("empty0_pass",  64'(pass),       64'd1);
      chk("empty0_count", 64'(word_count), 64'd0);
      tick();
      word(64'h1, 1'b1);
      chk("empty1_fail", 64'(fail), 64'd1);
      tick();

      // Exactly MAX_WORDS payload words is legal
      word(64'd1, 1'b0); word(64'd2, 1'b0); word(64'd4, 1'b0); word(64'd8, 1'b0);
      word(64'd15, 1'b1);
      chk("max_pass",  64'(pass),       64'd1);
      chk("max_ovf",   64'(overflow),   64'd0);
      chk("max_count", 64'(word_count), 64'd4);
      tick();

      // One word too many: verdict on the 5th accept, the remainder is swallowed
      n0 = ndone;
      word(64'd1, 1'b0); word(64'd2, 1'b0); word(64'd4, 1'b0); word(64'd8, 1'b0);
      word(64'd16, 1'b0);
      chk("ovf_done",  64'(done),       64'd1);
      chk("ovf_flag",  64'(overflow),   64'd1);
      chk("ovf_fail",  64'(fail),       64'd1);
      chk("ovf_pass",  64'(pass),       64'd0);
      chk("ovf_count", 64'(word_count), 64'd4);
      tick();
      chk("ovf_ready", 64'(in_ready), 64'd1);
      word(64'd32, 1'b0);
      word(64'd64, 1'b0);
      word(64'd0, 1'b1);
      tick();
      tick();
      chk("ovf_ndone", 64'(ndone - n0), 64'd1);
      chk("ovf_hold",  64'(overflow),   64'd1);

      // Reset mid-packet abandons it without a verdict
      word(64'd3, 1'b0);
      word(64'd5, 1'b0);
      n0 = ndone;
      reset = 1'b1;
      tick();
      chk("mid_rst_count", 64'(word_count), 64'd0);
      chk("mid_rst_ovf",   64'(overflow),   64'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_done", 64'(done), 64'd0);
      word(64'd3, 1'b0);
      word(64'd5, 1'b0);
      word(64'd6, 1'b1);
      chk("post_rst_pass",  64'(pass),        64'd1);
      chk("post_rst_count", 64'(word_count),  64'd2);
      chk("rst_no_done",    64'(ndone - n0),  64'd0);
      tick();

      // Toggled valid, and a word held during the verdict cycle
      word(64'd8324, 1'b0);
      tick();
      word(64'd7813266, 1'b0);
      tick();
      in_valid = 1'b1; in_data = 64'h771816; in_last = 1'b1;
      tick();
      in_data = 64'hAA; in_last = 1'b0;
      chk("tog_done",  64'(done),       64'd1);
      chk("tog_pass",  64'(pass),       64'd1);
      chk("tog_ready", 64'(in_ready),   64'd0);
      tick();
      chk("tog_not_taken", 64'(word_count), 64'd2);
      tick();
      in_valid = 1'b0;
      chk("tog_taken", 64'(word_count), 64'd1);
      word(64'hAA, 1'b1);
      chk("tog2_pass", 64'(pass), 64'd1);
      tick();

      // Long idle gap mid-packet
      word(64'd7, 1'b0);
      repeat (6) tick();
      chk("gap_count", 64'(word_count), 64'd1);
      word(64'd7, 1'b1);
      chk("gap_pass", 64'(pass), 64'd1);
      tick();
      tick();

      finished = 1'b1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
